uart_rx_deser: RTL and testbench
================================

UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s; BIT_CYC = CLK_FREQ/BAUD (integer divide), HALF_CYC = BIT_CYC/2.
REQ-003 clk  input  1  system clock; all logic is rising-edge on this one clock.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 uart_rx_pin  input  1  asynchronous serial line; idles high.
REQ-006 data_o  output  8  received byte, valid while valid_o=1.
REQ-007 valid_o  output  1  byte available in the output buffer.
REQ-008 ready_i  input  1  consumer accepts data_o when valid_o=1 and ready_i=1 on the same edge.
REQ-009 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun_o  output  1  one-cycle pulse: completed byte dropped because the buffer was full.
REQ-011 busy_o  output  1  high in any state other than IDLE.

Function
REQ-012 uart_rx_pin passes a 2-flop synchronizer; all decisions use the synchronized value rx_s; the synchronizer resets to 1.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: 1->0 transition of rx_s -> START; bit counter cleared; cycle counter cleared.
REQ-015 START: after HALF_CYC cycles sample rx_s; 0 -> DATA (cycle counter cleared); 1 -> IDLE as a false start, no output activity.
REQ-016 DATA: sample rx_s every BIT_CYC cycles; shift in LSB first; after the 8th sample -> STOP.
REQ-017 STOP: after BIT_CYC cycles sample rx_s; 1 -> byte complete, -> IDLE; 0 -> frame_err_o pulse, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s=1, then -> IDLE; a break condition therefore never produces a second error or a spurious start.
REQ-019 Byte complete with buffer empty, or with valid_o=1 and ready_i=1 on that same edge: data_o loads the new byte and valid_o is 1 on the next cycle.
REQ-020 Byte complete with valid_o=1 and ready_i=0: new byte dropped, data_o unchanged, overrun_o pulses for one cycle.
REQ-021 valid_o, once set, stays high and data_o stays stable until the accepting handshake; handshake with no new byte clears valid_o the next cycle.
REQ-022 ready_i while valid_o=0 has no effect.
REQ-023 The cycle counter is sized for BIT_CYC-1, saturates never, and restarts at 0 on every sample.
REQ-024 Latency from the stop-bit sample edge to valid_o high: exactly 1 cycle.
REQ-025 A start edge immediately after the stop sample (back-to-back frames) is detected; no idle bit is required beyond the stop bit.

Reset
REQ-026 While rst_n=0: FSM=IDLE, counters=0, shift register=0, data_o=8'h00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
REQ-027 Reset mid-frame discards the partial byte; after release a full frame with a valid start edge is required before any output.

Structure
REQ-028 The FSM state enumeration and the default CLK_FREQ/BAUD constants reside in the shared UART package.
REQ-029 The 2-flop synchronizer is a separate sub-module, sync_2ff, reset value parameterized (1 here).

Verification
REQ-030 CLK_FREQ=50000000, BAUD=115200 (BIT_CYC=434), ready_i=1, send 0x55 -> valid_o one cycle, data_o=0x55, no error pulses.
REQ-031 Low glitch of 100 cycles on an idle line -> no valid_o, no frame_err_o, busy_o returns to 0 by cycle HALF_CYC+3.
REQ-032 Frame 0xA3 with stop bit 0, line held low 2000 cycles, then high -> exactly one frame_err_o pulse, no valid_o, FSM back to IDLE.
REQ-033 ready_i=0, send 0x12 then 0x34 -> overrun_o one pulse at the second stop sample, data_o=0x12; raise ready_i -> valid_o clears the next cycle.
REQ-034 Assert rst_n=0 during bit 4 of 0x7E, release, send 0xC9 -> only 0xC9 delivered.
REQ-035 Four back-to-back frames 0x01 0x02 0x04 0x80, ready_i=1 -> four valid_o pulses in order, no errors.

Source files
------------

// File: rtl/uart_rx_deser_pkg.sv
// uart_rx_deser_pkg
//   Shared UART receive definitions: receiver FSM state enumeration,
//   default clock/line-rate constants and a counter-width helper.
package uart_rx_deser_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_deser_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input bit.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset; both flops load RESET_VAL
//     d     - asynchronous input
//     q     - synchronized output
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   8N1 UART receiver with a one-entry valid/ready output buffer.
//   The line is synchronized, a falling edge starts a frame, the start bit
//   is confirmed at mid-bit, eight data bits are sampled LSB first at
//   BIT_CYC intervals and the stop bit is checked. A low stop bit raises a
//   frame error and the receiver then waits for the line to return high.
//   Ports:
//     clk         - system clock, rising edge
//     rst_n       - asynchronous active-low reset
//     uart_rx_pin - asynchronous serial input, idles high
//     data_o      - received byte, valid while valid_o is high
//     valid_o     - output buffer holds a byte
//     ready_i     - consumer accepts data_o when valid_o and ready_i are high
//     frame_err_o - one-cycle pulse: stop bit sampled low
//     overrun_o   - one-cycle pulse: completed byte dropped, buffer full
//     busy_o      - receiver is not idle
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_pin,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CW       = cnt_width(BIT_CYC);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((HALF_CYC > 0) ? HALF_CYC - 1 : 0);

    rx_state_e     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shreg, shreg_next;
    logic          rx_s;
    logic          rx_prev;
    logic          byte_done;
    logic          stop_bad;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (uart_rx_pin),
        .q    (rx_s)
    );

    // Previous synchronized level, used to find the 1->0 start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        bit_next   = bit_idx;
        shreg_next = shreg;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_s) begin
                    state_next = START;
                    bit_next   = '0;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Output buffer: a completed byte loads if the buffer is empty or is
    // being emptied on this same edge; otherwise it is dropped as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= stop_bad;
            overrun_o   <= byte_done && valid_o && !ready_i;
            if (byte_done && (!valid_o || ready_i)) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
//   Directed and randomized frames driven onto the serial pin; a negedge
//   monitor records handshakes and pulse counts which are compared with
//   byte lists derived from the frame contents and the buffer rules.
module tb_uart_rx_deser;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 115_200;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int LAT_MIN  = HALF_CYC + 9 * BIT_CYC;
    localparam int LAT_MAX  = LAT_MIN + 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx_pin;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int last_rise = -1;
    int ovr_cyc = -1;
    int n_vcyc, n_ferr, n_ovr, n_busy;
    logic prev_valid = 1'b0;
    logic prev_ovr = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    uart_rx_deser #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx_pin(uart_rx_pin),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (valid_o && !prev_valid) last_rise = cyc;
        if (overrun_o && !prev_ovr) ovr_cyc = cyc;
        prev_valid = valid_o;
        prev_ovr   = overrun_o;
        if (valid_o) n_vcyc++;
        if (valid_o && ready_i) got.push_back(data_o);
        if (frame_err_o) n_ferr++;
        if (overrun_o) n_ovr++;
        if (busy_o) n_busy++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        n_vcyc = 0; n_ferr = 0; n_ovr = 0; n_busy = 0;
        last_rise = -1; ovr_cyc = -1;
        got.delete();
        exp_q.delete();
    endtask

    // Drive the pin to v for n clock cycles; returns at posedge + 2.
    task automatic hold(input logic v, input int n);
        uart_rx_pin = v;
        repeat (n) @(posedge clk);
        if (n > 0) #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        hold(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) hold(b[i], BIT_CYC);
        hold(stop, BIT_CYC);
    endtask

    task automatic compare_bytes(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i),
                  (i < got.size()) ? {24'h0, got[i]} : 32'hxxxx_xxxx, {24'h0, exp_q[i]});
    endtask

    initial begin
        logic [7:0] b;
        rst_n = 1'b0;
        uart_rx_pin = 1'b1;
        ready_i = 1'b1;
        @(posedge clk); #2;
        hold(1'b1, 5);
        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        check("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Single good frame, consumer always ready.
        clear_mon();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        hold(1'b1, 10);
        compare_bytes("t55");
        check("t55_valid_cycles", n_vcyc, 1);
        check("t55_ferr", n_ferr, 0);
        check("t55_ovr", n_ovr, 0);
        check("t55_latency_in_window",
              (last_rise - fall_cyc >= LAT_MIN) && (last_rise - fall_cyc <= LAT_MAX), 1);
        check("t55_busy_after", busy_o, 0);

        // Short low glitch on an idle line is a false start.
        clear_mon();
        hold(1'b0, 100);
        hold(1'b1, HALF_CYC + 3 - 100);
        check("glitch_busy_cleared", busy_o, 0);
        check("glitch_busy_seen", n_busy > 0, 1);
        hold(1'b1, 2 * BIT_CYC);
        check("glitch_valid", n_vcyc, 0);
        check("glitch_ferr", n_ferr, 0);

        // Bad stop bit followed by a long break.
        clear_mon();
        send_frame(8'hA3, 1'b0);
        hold(1'b0, 2000);
        hold(1'b1, 50);
        check("ferr_pulses", n_ferr, 1);
        check("ferr_valid", n_vcyc, 0);
        check("ferr_ovr", n_ovr, 0);
        check("ferr_busy_after", busy_o, 0);

        // Consumer stalled: second byte overruns, first byte held.
        clear_mon();
        ready_i = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        hold(1'b1, 20);
        check("ovr_pulses", n_ovr, 1);
        check("ovr_at_second_stop",
              (ovr_cyc - fall_cyc >= LAT_MIN) && (ovr_cyc - fall_cyc <= LAT_MAX), 1);
        check("ovr_valid_held", valid_o, 1);
        check("ovr_data_held", data_o, 8'h12);
        ready_i = 1'b1;
        hold(1'b1, 1);
        check("ovr_valid_cleared", valid_o, 0);
        exp_q.push_back(8'h12);
        compare_bytes("ovr");

        // Reset in the middle of bit 4 of 0x7E.
        clear_mon();
        b = 8'h7E;
        hold(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) hold(b[i], BIT_CYC);
        hold(b[4], HALF_CYC);
        rst_n = 1'b0;
        hold(1'b1, 3);
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_data", data_o, 0);
        rst_n = 1'b1;
        hold(1'b1, 6 * BIT_CYC);
        exp_q.push_back(8'hC9);
        send_frame(8'hC9, 1'b1);
        hold(1'b1, 10);
        compare_bytes("midrst");
        check("midrst_ferr", n_ferr, 0);

        // Back-to-back frames with no idle time beyond the stop bit.
        clear_mon();
        exp_q = '{8'h01, 8'h02, 8'h04, 8'h80};
        for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1);
        hold(1'b1, 10);
        compare_bytes("b2b");
        check("b2b_valid_cycles", n_vcyc, 4);
        check("b2b_ferr", n_ferr, 0);
        check("b2b_ovr", n_ovr, 0);

        // Random bytes with random idle gaps.
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            hold(1'b1, int'($urandom_range(0, 40)));
        end
        hold(1'b1, 10);
        compare_bytes("rand");
        check("rand_ferr", n_ferr, 0);
        check("rand_ovr", n_ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
